// File: rtl/inputreg_fifo_if.sv
// Handshake bundle for inputreg_fifo.
// master : producer/consumer side. It drives Flush, Write_En, Write_Data and
//          Read_En, and observes the head word, the occupancy flags and the
//          error flags.
// slave  : the FIFO itself. It drives Read_Data, Valid, Full, Empty, Count,
//          Ovf_Err and Udf_Err.
interface inputreg_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              Flush;
  logic              Write_En;
  logic [DWIDTH-1:0] Write_Data;
  logic              Read_En;
  logic [DWIDTH-1:0] Read_Data;
  logic              Valid;
  logic              Full;
  logic              Empty;
  logic [CW-1:0]     Count;
  logic              Ovf_Err;
  logic              Udf_Err;

  modport master (
    output Flush, Write_En, Write_Data, Read_En,
    input  Read_Data, Valid, Full, Empty, Count, Ovf_Err, Udf_Err
  );

  modport slave (
    input  Flush, Write_En, Write_Data, Read_En,
    output Read_Data, Valid, Full, Empty, Count, Ovf_Err, Udf_Err
  );
endinterface

// File: rtl/inputreg_fifo.sv
// inputreg_fifo: operand input buffer for a CGRA PE.
//
// Words pushed by a neighbour are presented in order, first-word-fall-through,
// to the PE datapath.
//
// Ports:
//   Clk   : rising-edge clock.
//   Reset : synchronous, active-high reset.
//   bus   : inputreg_fifo_if.slave. It carries Flush, the Write_En/Write_Data
//           push request, the Read_En pop request, Read_Data, the
//           Valid/Full/Empty/Count flags, and the sticky Ovf_Err/Udf_Err flags.
//
// Optional feature: define INPUTREG_ERR_FLAGS_EN to build the sticky
// overflow/underflow flags. Without it, both flags are tied to 0.
module inputreg_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  inputreg_fifo_if.slave       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic empty, full, rd_ok, wr_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign rd_ok = bus.Read_En && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still
  // accepted in that cycle.
  assign wr_ok = bus.Write_En && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointer width equals log2(DEPTH), so the +1 wraps on its own.
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || bus.Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; stale contents are masked by the occupancy count.
  always_ff @(posedge Clk) begin
    if (wr_ok && !Reset && !bus.Flush) mem_q[wr_ptr_q] <= bus.Write_Data;
  end

  assign bus.Read_Data = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.Valid     = !empty;
  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.Count     = cnt_q;

`ifdef INPUTREG_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Flush discards same-cycle requests, so they cannot raise a flag.
  // Flush leaves the flags as they are; only Reset clears them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!bus.Flush) begin
      if (bus.Write_En && !wr_ok) ovf_q <= 1'b1;
      if (bus.Read_En && empty)   udf_q <= 1'b1;
    end
  end

  assign bus.Ovf_Err = ovf_q;
  assign bus.Udf_Err = udf_q;
`else
  assign bus.Ovf_Err = 1'b0;
  assign bus.Udf_Err = 1'b0;
`endif
endmodule

// File: tb/tb_inputreg_fifo.sv
module tb_inputreg_fifo;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 4;

`ifdef INPUTREG_ERR_FLAGS_EN
  localparam logic FLAG_ON = 1'b1;
`else
  localparam logic FLAG_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;

  inputreg_fifo_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();

  inputreg_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.Write_En = 1'b1;
    bus.Write_Data = d;
    tick();
    bus.Write_En = 1'b0;
  endtask

  task automatic pop();
    bus.Read_En = 1'b1;
    tick();
    bus.Read_En = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (bus.Count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", bus.Count);
    end
    checks++;
    if ({bus.Empty, bus.Full, bus.Valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got E/F/V=%b exp=100", {bus.Empty, bus.Full, bus.Valid});
    end
    checks++;
    if (bus.Read_Data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", bus.Read_Data);
    end
    checks++;
    if ({bus.Ovf_Err, bus.Udf_Err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_errs got=%b exp=00", {bus.Ovf_Err, bus.Udf_Err});
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] w [3];
    w = '{32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 3; i++) begin
      push(w[i]);
      checks++;
      if (bus.Count !== 3'(i + 1)) begin
        failures++;
        $display("FAIL fd_count_up[%0d] got=%0d exp=%0d", i, bus.Count, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.Read_Data !== w[i]) begin
        failures++;
        $display("FAIL fd_rdata[%0d] got=%h exp=%h", i, bus.Read_Data, w[i]);
      end
      pop();
    end
    checks++;
    if (bus.Count !== 3'd0 || bus.Empty !== 1'b1 || bus.Read_Data !== 32'h0) begin
      failures++;
      $display("FAIL fd_end got cnt=%0d E=%b rd=%h exp cnt=0 E=1 rd=0", bus.Count, bus.Empty, bus.Read_Data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      push(32'h10 + i);
      if (i == 3) begin
        checks++;
        if (bus.Full !== 1'b1 || bus.Count !== 3'd4) begin
          failures++;
          $display("FAIL ovf_full got F=%b cnt=%0d exp F=1 cnt=4", bus.Full, bus.Count);
        end
      end
    end
    checks++;
    if (bus.Count !== 3'd4 || bus.Ovf_Err !== FLAG_ON) begin
      failures++;
      $display("FAIL ovf_drop got cnt=%0d ovf=%b exp cnt=4 ovf=%b", bus.Count, bus.Ovf_Err, FLAG_ON);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.Read_Data !== 32'h10 + i) begin
        failures++;
        $display("FAIL ovf_rdata[%0d] got=%h exp=%h", i, bus.Read_Data, 32'h10 + i);
      end
      pop();
    end
    checks++;
    if (bus.Empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty got=%b exp=1", bus.Empty);
    end
  endtask

  task automatic test_full_rw();
    logic [31:0] exp [4];
    exp = '{32'h11, 32'h12, 32'h13, 32'h55};
    for (int i = 0; i < 4; i++) push(32'h10 + i);
    bus.Write_En = 1'b1;
    bus.Read_En = 1'b1;
    bus.Write_Data = 32'h55;
    tick();
    bus.Write_En = 1'b0;
    bus.Read_En = 1'b0;
    checks++;
    if (bus.Count !== 3'd4 || bus.Full !== 1'b1 || bus.Ovf_Err !== FLAG_ON) begin
      failures++;
      $display("FAIL frw_state got cnt=%0d F=%b ovf=%b exp cnt=4 F=1 ovf=%b", bus.Count, bus.Full, bus.Ovf_Err, FLAG_ON);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.Read_Data !== exp[i]) begin
        failures++;
        $display("FAIL frw_rdata[%0d] got=%h exp=%h", i, bus.Read_Data, exp[i]);
      end
      pop();
    end
  endtask

  task automatic test_empty_rw();
    checks++;
    if (bus.Udf_Err !== 1'b0) begin
      failures++;
      $display("FAIL erw_udf_pre got=%b exp=0", bus.Udf_Err);
    end
    bus.Write_En = 1'b1;
    bus.Read_En = 1'b1;
    bus.Write_Data = 32'h77;
    tick();
    bus.Write_En = 1'b0;
    bus.Read_En = 1'b0;
    checks++;
    if (bus.Count !== 3'd1 || bus.Read_Data !== 32'h77 || bus.Valid !== 1'b1) begin
      failures++;
      $display("FAIL erw_push got cnt=%0d rd=%h V=%b exp cnt=1 rd=77 V=1", bus.Count, bus.Read_Data, bus.Valid);
    end
    pop();
    pop();
    checks++;
    if (bus.Count !== 3'd0 || bus.Udf_Err !== FLAG_ON) begin
      failures++;
      $display("FAIL erw_udf got cnt=%0d udf=%b exp cnt=0 udf=%b", bus.Count, bus.Udf_Err, FLAG_ON);
    end
  endtask

  task automatic test_back_to_back();
    push(32'h100);
    push(32'h101);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.Read_Data !== 32'h100 + i) begin
        failures++;
        $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, bus.Read_Data, 32'h100 + i);
      end
      bus.Write_En = 1'b1;
      bus.Read_En = 1'b1;
      bus.Write_Data = 32'h102 + i;
      tick();
      checks++;
      if (bus.Count !== 3'd2) begin
        failures++;
        $display("FAIL b2b_count[%0d] got=%0d exp=2", i, bus.Count);
      end
    end
    bus.Write_En = 1'b0;
    bus.Read_En = 1'b0;
    for (int i = 10; i < 12; i++) begin
      checks++;
      if (bus.Read_Data !== 32'h100 + i) begin
        failures++;
        $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, bus.Read_Data, 32'h100 + i);
      end
      pop();
    end
  endtask

  task automatic test_flush();
    push(32'h31);
    push(32'h32);
    push(32'h33);
    checks++;
    if (bus.Count !== 3'd3) begin
      failures++;
      $display("FAIL fl_pre got=%0d exp=3", bus.Count);
    end
    bus.Flush = 1'b1;
    bus.Write_En = 1'b1;
    bus.Write_Data = 32'h99;
    tick();
    bus.Flush = 1'b0;
    bus.Write_En = 1'b0;
    checks++;
    if (bus.Count !== 3'd0 || bus.Empty !== 1'b1 || bus.Read_Data !== 32'h0) begin
      failures++;
      $display("FAIL fl_clear got cnt=%0d E=%b rd=%h exp cnt=0 E=1 rd=0", bus.Count, bus.Empty, bus.Read_Data);
    end
    checks++;
    if ({bus.Ovf_Err, bus.Udf_Err} !== {FLAG_ON, FLAG_ON}) begin
      failures++;
      $display("FAIL fl_errs got=%b exp=%b", {bus.Ovf_Err, bus.Udf_Err}, {FLAG_ON, FLAG_ON});
    end
    push(32'h42);
    checks++;
    if (bus.Read_Data !== 32'h42 || bus.Count !== 3'd1) begin
      failures++;
      $display("FAIL fl_after got rd=%h cnt=%0d exp rd=42 cnt=1", bus.Read_Data, bus.Count);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if ({bus.Ovf_Err, bus.Udf_Err} !== 2'b00 || bus.Count !== 3'd0) begin
      failures++;
      $display("FAIL fl_reset got errs=%b cnt=%0d exp errs=00 cnt=0", {bus.Ovf_Err, bus.Udf_Err}, bus.Count);
    end
  endtask

  initial begin
    bus.Flush = 1'b0;
    bus.Write_En = 1'b0;
    bus.Read_En = 1'b0;
    bus.Write_Data = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
